// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : HI/LO multiply-divide unit (multi-cycle MULT, restoring DIV)
// Revision 1.0
// ============================================================================

package mult_div_pkg;
    typedef enum logic [2:0] {
        CLR   = 3'd0,
        MULT  = 3'd1,
        MULTU = 3'd2,
        DIV   = 3'd3,
        DIVU  = 3'd4
    } mult_t;
endpackage

module mult_div_unit
    import mult_div_pkg::*;
#(
    parameter int MUL_CYCLES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  mult_t       op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_MUL      = 2'd1;
    localparam logic [1:0] c_DIV      = 2'd2;
    localparam logic [4:0] c_MUL_LAST = 5'(MUL_CYCLES - 1);
    localparam logic [4:0] c_DIV_LAST = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_nextState;
    logic [4:0]  r_cnt;
    logic [31:0] r_opA;        // multiplicand, or dividend magnitude shifting out
    logic [31:0] r_opB;        // multiplier, or divisor magnitude
    logic [31:0] r_rem;
    logic        r_mulSigned;
    logic        r_qNeg;
    logic        r_rNeg;
    logic        r_divZero;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_isDivOp;
    logic        w_last;
    logic [63:0] w_mulA;
    logic [63:0] w_mulB;
    logic [63:0] w_prod;
    logic [32:0] w_shift;
    logic [32:0] w_diff;
    logic        w_qBit;
    logic [31:0] w_remNext;
    logic [31:0] w_quotNext;

    assign w_isDivOp = (op == DIV) || (op == DIVU);
    assign w_accept  = (r_state == c_IDLE) && start && !flush &&
                       ((op == MULT) || (op == MULTU) || w_isDivOp);

    // Sign-extending to 64 bits lets one unsigned multiply serve both forms.
    assign w_mulA = {{32{r_mulSigned & r_opA[31]}}, r_opA};
    assign w_mulB = {{32{r_mulSigned & r_opB[31]}}, r_opB};
    assign w_prod = w_mulA * w_mulB;

    assign w_shift    = {r_rem, r_opA[31]};
    assign w_diff     = w_shift - {1'b0, r_opB};
    assign w_qBit     = ~w_diff[32];
    assign w_remNext  = w_qBit ? w_diff[31:0] : w_shift[31:0];
    assign w_quotNext = {r_opA[30:0], w_qBit};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_IDLE;
        else         r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_nextState = w_isDivOp ? c_DIV : c_MUL;
            c_MUL,
            c_DIV:   if (flush || w_last) w_nextState = c_IDLE;
            default: w_nextState = c_IDLE;
        endcase
    end

    always_comb begin
        busy   = (r_state != c_IDLE);
        w_last = ((r_state == c_MUL) && (r_cnt == c_MUL_LAST)) ||
                 ((r_state == c_DIV) && (r_cnt == c_DIV_LAST));
        done   = w_last && !flush;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_opA       <= '0;
            r_opB       <= '0;
            r_rem       <= '0;
            r_mulSigned <= 1'b0;
            r_qNeg      <= 1'b0;
            r_rNeg      <= 1'b0;
            r_divZero   <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            if (w_accept) begin
                r_cnt       <= '0;
                r_opA       <= ((op == DIV) && a[31]) ? -a : a;
                r_opB       <= ((op == DIV) && b[31]) ? -b : b;
                r_rem       <= '0;
                r_mulSigned <= (op == MULT);
                r_qNeg      <= (op == DIV) && (a[31] ^ b[31]);
                r_rNeg      <= (op == DIV) && a[31];
                r_divZero   <= (b == '0);
            end else if (busy && !flush && !w_last) begin
                r_cnt <= r_cnt + 5'd1;
            end else begin
                r_cnt <= '0;
            end

            if (r_state == c_DIV) begin
                r_rem <= w_remNext;
                r_opA <= w_quotNext;
            end

            // MTHI/MTLO only land while idle; results only on an unflushed final cycle.
            if (r_state == c_IDLE) begin
                if (hi_we) r_hi <= wdata;
                if (lo_we) r_lo <= wdata;
            end else if (done) begin
                if (r_state == c_MUL) begin
                    r_hi <= w_prod[63:32];
                    r_lo <= w_prod[31:0];
                end else if (!r_divZero) begin
                    r_hi <= r_rNeg ? -w_remNext  : w_remNext;
                    r_lo <= r_qNeg ? -w_quotNext : w_quotNext;
                end
            end
        end
    end

    assign hi = r_hi;
    assign lo = r_lo;

endmodule
`default_nettype wire
